// File: rtl/display_pkg.sv
// Shared definitions for seven-segment display logic.
//   - segment bit order (active-low bus, seg[6]=a ... seg[0]=g)
//   - SEG_BLANK and the 16 hex glyphs
//   - default prescaler divides per board clock
//   - hex_glyph(): nibble-to-glyph lookup
package display_pkg;

  // Segment bit positions on the 7-bit bus.
  localparam int SEG_W = 7;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-low glyphs: a 0 bit lights the segment.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_0   = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4   = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6   = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7   = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A   = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B   = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C   = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D   = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E   = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F   = 7'b0111000;

  // Cycles per lit digit, giving roughly 1 kHz digit rate per board clock.
  localparam int REFRESH_DIV_50MHZ   = 50000;
  localparam int REFRESH_DIV_100MHZ  = 100000;
  localparam int DEFAULT_REFRESH_DIV = REFRESH_DIV_50MHZ;

  function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nibble);
    logic [SEG_W-1:0] g;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   nibble : in  4  hex digit
//   seg    : out 7  active-low segments, seg[6]=a ... seg[0]=g
module hex7seg_decoder
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = hex_glyph(nibble);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode
// seven-segment bank. A loaded value waits in a shadow register and is
// promoted to the displayed (active) value only at a frame boundary, so a
// frame never mixes old and new digits.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : in  1  scan enable; 0 blanks and freezes scanning
//   load       : in  1  one-cycle capture request for value
//   value      : in  4*N_DIGITS packed nibbles, digit 0 rightmost
//   blank_lz   : in  1  blank leading zero digits
//   seg        : out 7  active-low segments (registered)
//   an         : out N_DIGITS active-low digit enables (registered)
//   pending    : out 1  shadow holds a value not yet displayed
//   frame_done : out 1  one-cycle pulse at each frame boundary (registered)
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VAL_W  = 4 * N_DIGITS;

  localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

  logic [PCNT_W-1:0] pcnt;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  shadow;
  logic [VAL_W-1:0]  active;
  // Set by the first tick after reset; until then nothing is lit, so the
  // first digit appears together with the first frame boundary.
  logic              lit;

  logic              tick;
  logic              boundary;
  logic [IDX_W-1:0]  idx_nxt;
  logic [VAL_W-1:0]  active_nxt;
  logic              lz_blank;
  logic [3:0]        nibble;
  logic [SEG_W-1:0]  glyph;
  logic              show;

  assign tick     = en && (pcnt == PCNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Next digit index and displayed value. The output registers are fed
  // from these so an/seg change on the same edge as idx/active.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    idx_nxt    = idx;
    active_nxt = active;
    if (tick) begin
      idx_nxt = boundary ? '0 : idx + IDX_W'(1);
    end
    if (boundary) begin
      // A load landing on the boundary wins over the older shadow.
      if (load) begin
        active_nxt = value;
      end else if (pending) begin
        active_nxt = shadow;
      end
    end
  end

  // Leading-zero mask: digit i>0 blanks when nibbles i..N-1 are all zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (active_nxt[4*i +: 4] == 4'h0);
      if (int'(idx_nxt) == i) begin
        lz_blank = blank_lz && zero_above;
      end
    end
  end

  assign nibble = active_nxt[4*int'(idx_nxt) +: 4];

  hex7seg_decoder u_decoder (
    .nibble (nibble),
    .seg    (glyph)
  );

  assign show = en && (lit || tick) && !lz_blank;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= IDX_LAST;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      lit        <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
    end else begin
      if (en) begin
        pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
      end
      idx        <= idx_nxt;
      active     <= active_nxt;
      lit        <= lit || tick;
      frame_done <= boundary;

      if (load && !boundary) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      an  <= show ? ~(AN_ONE << idx_nxt) : '1;
      seg <= show ? glyph : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, REFRESH_DIV=4.
// Edge k is the k-th rising clock edge after reset release; outputs are
// sampled 1 time unit after that edge and inputs are driven there too.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS    (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @edge %0d: got 'h%0h expected 'h%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to just after edge `target`.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_an",   32'(an), 32'hF);
    check("rst_seg",  32'(seg), 32'(BL));
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_fd",   32'(frame_done), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // First frame: blank for 3 edges, digit 0 at edge 4 with frame_done.
    goto(1); check("pre_an1", 32'(an), 32'hF);
    goto(2); check("pre_an2", 32'(an), 32'hF);
    goto(3); check("pre_an3", 32'(an), 32'hF);
    check("pre_fd3", 32'(frame_done), 32'd0);
    goto(4); check("tick_an", 32'(an), 32'hE);
    check("tick_seg", 32'(seg), 32'(G0));
    check("tick_fd",  32'(frame_done), 32'd1);
    goto(5); check("fd_pulse", 32'(frame_done), 32'd0);
    check("d0_hold",  32'(an), 32'hE);
    goto(8);  check("rot_an1", 32'(an), 32'hD);
    goto(12); check("rot_an2", 32'(an), 32'hB);
    goto(16); check("rot_an3", 32'(an), 32'h7);
    goto(20); check("rot_wrap", 32'(an), 32'hE);
    check("wrap_fd", 32'(frame_done), 32'd1);

    // Mid-frame load of 1A3F; shown from the boundary at edge 36.
    goto(21);
    load = 1'b1; value = 16'h1A3F;
    goto(22);
    load = 1'b0;
    check("ld_pend", 32'(pending), 32'd1);
    goto(35);
    check("ld_pend_hold", 32'(pending), 32'd1);
    check("ld_old_seg",   32'(seg), 32'(G0));
    goto(36);
    check("ld_pend_clr", 32'(pending), 32'd0);
    check("ld_d0_an",    32'(an), 32'hE);
    check("ld_d0_seg",   32'(seg), 32'(GF));
    goto(40); check("ld_d1_seg", 32'(seg), 32'(G3));
    goto(44); check("ld_d2_seg", 32'(seg), 32'(GA));
    goto(48); check("ld_d3_seg", 32'(seg), 32'(G1));
    check("ld_d3_an", 32'(an), 32'h7);

    // Shadow holds 1111, then 0005 is loaded on the boundary edge 52.
    load = 1'b1; value = 16'h1111;
    goto(49);
    load = 1'b0;
    check("bl_pend", 32'(pending), 32'd1);
    goto(51);
    load = 1'b1; value = 16'h0005;
    goto(52);
    load = 1'b0;
    check("bl_seg",  32'(seg), 32'(G5));
    check("bl_an",   32'(an), 32'hE);
    check("bl_pend", 32'(pending), 32'd0);
    check("bl_fd",   32'(frame_done), 32'd1);
    goto(56); check("bl_d1_seg", 32'(seg), 32'(G0));

    // Leading-zero blanking; 0040 becomes active at edge 68.
    blank_lz = 1'b1;
    load = 1'b1; value = 16'h0040;
    goto(57);
    load = 1'b0;
    goto(60); check("lz5_d2_an", 32'(an), 32'hF);
    check("lz5_d2_seg", 32'(seg), 32'(BL));
    goto(64); check("lz5_d3_an", 32'(an), 32'hF);
    goto(68); check("lz_d0_an",  32'(an), 32'hE);
    check("lz_d0_seg", 32'(seg), 32'(G0));
    goto(72); check("lz_d1_an",  32'(an), 32'hD);
    check("lz_d1_seg", 32'(seg), 32'(G4));
    goto(76); check("lz_d2_an",  32'(an), 32'hF);
    check("lz_d2_seg", 32'(seg), 32'(BL));
    goto(80); check("lz_d3_an",  32'(an), 32'hF);

    // Drop en for 10 edges (86..95) after digit 0 has been lit 2 cycles.
    goto(85);
    en = 1'b0;
    goto(86);
    check("en0_an",  32'(an), 32'hF);
    check("en0_seg", 32'(seg), 32'(BL));
    goto(88);
    load = 1'b1; value = 16'h0007;
    goto(89);
    load = 1'b0;
    check("en0_pend", 32'(pending), 32'd1);
    goto(95);
    check("en0_fd",  32'(frame_done), 32'd0);
    check("en0_an2", 32'(an), 32'hF);
    en = 1'b1;
    goto(96); check("en1_an", 32'(an), 32'hE);
    goto(97); check("en1_an_hold", 32'(an), 32'hE);
    goto(98); check("en1_adv_an", 32'(an), 32'hD);
    check("en1_adv_seg",  32'(seg), 32'(G4));
    check("en1_no_fd",    32'(frame_done), 32'd0);
    check("en1_pend",     32'(pending), 32'd1);

    // Asynchronous reset mid-cycle with pending set.
    goto(99);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an",   32'(an), 32'hF);
    check("arst_seg",  32'(seg), 32'(BL));
    check("arst_pend", 32'(pending), 32'd0);
    check("arst_fd",   32'(frame_done), 32'd0);
    #1 rst_n = 1'b1;
    goto(102); check("arst_pre_an", 32'(an), 32'hF);
    goto(103); check("arst_tick_an", 32'(an), 32'hE);
    check("arst_tick_fd", 32'(frame_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
